// File: rtl/seq_mul_param.sv
// Parametrised sequential shift-add multiplier.
// Operands are reduced to magnitudes on start, multiplied over WIDTH iterations, and the
// sign is reapplied in a final FIX cycle. The product is held until the next FIX.
module seq_mul_param #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic               neg_q, neg_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH-1:0]   in_mag_a, in_mag_b;
  logic [WIDTH:0]     sum;
  logic               add_c;
  logic [WIDTH-1:0]   add_hi;

  // Operand magnitudes; the most negative value maps onto 2^(W-1), which still fits.
  always_comb begin
    in_mag_a = a;
    in_mag_b = b;
    if (signed_mode && a[WIDTH-1]) in_mag_a = -a;
    if (signed_mode && b[WIDTH-1]) in_mag_b = -b;
  end

  // Conditional add of the multiplicand, carry kept for the shift.
  always_comb begin
    sum = {1'b0, acc_hi_q} + {1'b0, mag_a_q};
    if (acc_lo_q[0]) begin
      add_c  = sum[WIDTH];
      add_hi = sum[WIDTH-1:0];
    end else begin
      add_c  = 1'b0;
      add_hi = acc_hi_q;
    end
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d  = state_q;
    mag_a_d  = mag_a_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          mag_a_d  = in_mag_a;
          acc_hi_d = '0;
          acc_lo_d = in_mag_b;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          cnt_d    = CntW'(WIDTH);
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_hi_d = {add_c, add_hi[WIDTH-1:1]};
        acc_lo_d = {add_hi[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CntW'(1);
        // Last iteration is the one that brings the counter from 1 to 0.
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        prod_d  = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      mag_a_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mag_a_q  <= mag_a_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      prod_q   <= prod_d;
    end
  end

  // Outputs straight from registers/state.
  always_comb begin
    busy = (state_q == StRun) || (state_q == StFix);
    done = done_q;
    prod = prod_q;
  end

endmodule

// File: tb/tb_seq_mul_param.sv
// Directed bench for seq_mul_param: WIDTH=8 instance plus a WIDTH=16 instance.
module tb_seq_mul_param;

  logic        clk;
  logic        reset;
  logic        start, signed_mode;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] prod;

  logic        start16, signed_mode16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [31:0] prod16;

  int n_tests = 0;
  int n_fail  = 0;

  seq_mul_param #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .prod        (prod)
  );

  seq_mul_param #(.WIDTH(16)) dut16 (
    .clk         (clk),
    .reset       (reset),
    .start       (start16),
    .signed_mode (signed_mode16),
    .a           (a16),
    .b           (b16),
    .busy        (busy16),
    .done        (done16),
    .prod        (prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge, then scramble the inputs.
  task automatic launch(input logic sm, input logic [7:0] va, input logic [7:0] vb);
    start = 1'b1;
    signed_mode = sm;
    a = va;
    b = vb;
    tick();
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    signed_mode = 1'($urandom);
  endtask

  // Wait (bounded) for done; optionally check prod holds a previous value meanwhile.
  task automatic wait_done(output int lat, output int busy_cnt, input bit chk_hold,
                           input logic [15:0] hold_val);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 30) begin
      if (busy) busy_cnt++;
      if (chk_hold) check("prod_hold", 64'(prod), 64'(hold_val));
      tick();
      lat++;
    end
  endtask

  // Full operation; returns in the done cycle.
  task automatic run_op(input string tag, input logic sm, input logic [7:0] va,
                        input logic [7:0] vb, input logic [15:0] exp);
    int lat, bc;
    launch(sm, va, vb);
    wait_done(lat, bc, 1'b0, 16'h0);
    check({tag, "_lat"}, 64'(lat), 64'd9);
    check({tag, "_busy_cycles"}, 64'(bc), 64'd9);
    check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    check({tag, "_prod"}, 64'(prod), 64'(exp));
  endtask

  initial begin
    int lat, bc, dcnt;
    reset = 1'b0;
    start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    start16 = 1'b0; signed_mode16 = 1'b0; a16 = '0; b16 = '0;
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_prod", 64'(prod), 64'd0);
    check("rst_prod16", 64'(prod16), 64'd0);
    #9 reset = 1'b1;
    tick();

    // Unsigned full-scale; done is a single-cycle pulse.
    run_op("u255x255", 1'b0, 8'd255, 8'd255, 16'hFE01);
    tick();
    check("u255_done_pulse", 64'(done), 64'd0);
    check("u255_prod_held", 64'(prod), 64'hFE01);

    // Signed cases, including the most negative operand.
    run_op("s_m3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
    tick();
    run_op("s_80x80", 1'b1, 8'h80, 8'h80, 16'h4000);
    tick();
    run_op("s_80x7f", 1'b1, 8'h80, 8'h7F, 16'hC080);
    tick();
    run_op("s_0xm1", 1'b1, 8'h00, 8'hFF, 16'h0000);
    tick();

    // start held then re-pulsed while busy, with different operands.
    start = 1'b1; signed_mode = 1'b0; a = 8'd200; b = 8'd3;
    tick();
    lat = 0;
    while (!done && lat < 30) begin
      start = (lat < 5 || lat == 7) ? 1'b1 : 1'b0;
      a = 8'd7; b = 8'd7; signed_mode = 1'b1;
      tick();
      lat++;
    end
    start = 1'b0;
    check("busy_start_lat", 64'(lat), 64'd9);
    check("busy_start_prod", 64'(prod), 64'h0258);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dcnt++;
    end
    check("busy_start_extra_done", 64'(dcnt), 64'd0);
    check("busy_start_idle", 64'(busy), 64'd0);

    // Reset asserted during RUN iteration 4.
    launch(1'b0, 8'd50, 8'd50);
    tick(); tick(); tick();
    check("mid_busy_before", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_prod", 64'(prod), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done || busy) dcnt++;
    end
    check("mid_rst_quiet", 64'(dcnt), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_op("after_rst_12x10", 1'b0, 8'd12, 8'd10, 16'h0078);
    tick();

    // Back-to-back: second start issued in the done cycle of the first.
    run_op("b2b_first", 1'b0, 8'd12, 8'd13, 16'h009C);
    launch(1'b0, 8'd0, 8'd9);
    wait_done(lat, bc, 1'b1, 16'h009C);
    check("b2b_lat", 64'(lat), 64'd9);
    check("b2b_prod", 64'(prod), 64'h0000);
    tick();

    // WIDTH=16 unsigned full-scale.
    start16 = 1'b1; signed_mode16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF;
    tick();
    start16 = 1'b0; a16 = 16'h1234; b16 = 16'h5678;
    lat = 0;
    while (!done16 && lat < 50) begin
      tick();
      lat++;
    end
    check("w16_lat", 64'(lat), 64'd17);
    check("w16_prod", 64'(prod16), 64'hFFFE0001);
    tick();
    check("w16_done_pulse", 64'(done16), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
